// File: rtl/reduce_pkg.sv
// Shared op encoding and elaboration-time helpers for the pipelined reduction gate.
package reduce_pkg;

  typedef enum logic [2:0] {
    RED_AND    = 3'b000,
    RED_OR     = 3'b001,
    RED_XOR    = 3'b010,
    RED_RSVD   = 3'b011,
    RED_NAND   = 3'b100,
    RED_NOR    = 3'b101,
    RED_XNOR   = 3'b110,
    RED_RSVD_N = 3'b111
  } red_op_e;

  // Neutral lane value for the base op, so padded lanes never alter the result.
  function automatic logic identity(input logic [2:0] op);
    case (red_op_e'({1'b0, op[1:0]}))
      RED_OR, RED_XOR: return 1'b0;
      default:         return 1'b1;
    endcase
  endfunction

  function automatic int clog_base(input int n, input int b);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * b;
      l = l + 1;
    end
    return (l < 1) ? 1 : l;
  endfunction

  function automatic int level_width(input int width, input int fanin, input int k);
    int w;
    w = width;
    for (int i = 0; i <= k; i++) w = (w + fanin - 1) / fanin;
    return w;
  endfunction

  function automatic int level_offset(input int width, input int fanin, input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o = o + level_width(width, fanin, i);
    return o;
  endfunction

endpackage

// File: rtl/reduce_gate_pipelined_node.sv
// Single FANIN-input combinational gate; the op selects AND, OR or XOR (reserved acts as AND).
module reduce_node
  import reduce_pkg::*;
#(
  parameter int FANIN = 4
) (
  input  logic [1:0]       op,
  input  logic [FANIN-1:0] lanes,
  output logic             y
);

  always_comb begin
    case (red_op_e'({1'b0, op}))
      RED_OR:  y = |lanes;
      RED_XOR: y = ^lanes;
      default: y = &lanes;
    endcase
  end

endmodule

// File: rtl/reduce_gate_pipelined.sv
// Pipelined WIDTH-bit reduction gate: one register level per FANIN-ary tree level,
// valid/ready on both sides with a bubble-collapsing advance chain.
module reduce_gate_pipelined
  import reduce_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int FANIN = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit
);

  localparam int LEVELS = clog_base(WIDTH, FANIN);
  localparam int TOTAL  = level_offset(WIDTH, FANIN, LEVELS);

  // All level partials packed back to back; the last level is the single result bit.
  logic [TOTAL-1:0]  part_q;
  logic [LEVELS-1:0] valid_q;
  logic [2:0]        op_q [LEVELS];
  logic [LEVELS:0]   adv;

  assign adv[LEVELS] = out_ready;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IW  = (k == 0) ? WIDTH : level_width(WIDTH, FANIN, k - 1);
    localparam int OW  = level_width(WIDTH, FANIN, k);
    localparam int OFF = level_offset(WIDTH, FANIN, k);

    logic [IW-1:0]       src;
    logic [2:0]          src_op;
    logic                src_valid;
    logic [OW*FANIN-1:0] padded;
    logic [OW-1:0]       red;
    logic [OW-1:0]       nxt;

    if (k == 0) begin : g_head
      assign src       = in_data;
      assign src_op    = in_op;
      assign src_valid = in_valid;
    end else begin : g_body
      assign src       = part_q[level_offset(WIDTH, FANIN, k - 1) +: IW];
      assign src_op    = op_q[k-1];
      assign src_valid = valid_q[k-1];
    end

    for (genvar j = 0; j < OW * FANIN; j++) begin : g_lane
      if (j < IW) begin : g_real
        assign padded[j] = src[j];
      end else begin : g_pad
        assign padded[j] = identity(src_op);
      end
    end

    for (genvar g = 0; g < OW; g++) begin : g_grp
      reduce_node #(.FANIN(FANIN)) u_node (
        .op    (src_op[1:0]),
        .lanes (padded[g*FANIN +: FANIN]),
        .y     (red[g])
      );
    end

    if (k == LEVELS - 1) begin : g_last
      assign nxt = red ^ {OW{src_op[2]}};
    end else begin : g_mid
      assign nxt = red;
      always_ff @(posedge clk) begin
        if (!reset_n) op_q[k] <= '0;
        else if (adv[k]) op_q[k] <= src_op;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        valid_q[k]       <= 1'b0;
        part_q[OFF+:OW]  <= '0;
      end else if (adv[k]) begin
        valid_q[k]       <= src_valid;
        part_q[OFF+:OW]  <= nxt;
      end
    end

    assign adv[k] = !valid_q[k] || adv[k+1];
  end

  assign in_ready  = reset_n && adv[0];
  assign out_valid = valid_q[LEVELS-1];
  assign out_bit   = part_q[TOTAL-1];

endmodule

// File: tb/tb_reduce_gate_pipelined.sv
// Scoreboard bench: a 64-bit/FANIN-4 instance and a 10-bit padded instance.
module tb_reduce_gate_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_bit;
  logic [63:0] in_data;
  logic [2:0]  in_op;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_bit_b;
  logic [9:0]  in_data_b;
  logic [2:0]  in_op_b;

  reduce_gate_pipelined #(.WIDTH(64), .FANIN(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit)
  );

  reduce_gate_pipelined #(.WIDTH(10), .FANIN(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_op(in_op_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_bit(out_bit_b)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic exp_q[$];
  logic exp_qb[$];
  int   pop_cyc[$];
  logic rnd_on = 1'b0;
  logic e_a, e_b;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rnd_on) out_ready = 1'($urandom_range(0, 1));

  always @(negedge clk) begin
    #2;
    if (reset_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%0b want=none", out_bit);
      end else begin
        e_a = exp_q.pop_front();
        if (out_bit !== e_a) begin
          bad++;
          $display("FAIL result got=%0b want=%0b cyc=%0d", out_bit, e_a, cyc);
        end
      end
      pop_cyc.push_back(cyc);
    end
    if (reset_n && out_valid_b && out_ready_b) begin
      total++;
      if (exp_qb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_b got=%0b want=none", out_bit_b);
      end else begin
        e_b = exp_qb.pop_front();
        if (out_bit_b !== e_b) begin
          bad++;
          $display("FAIL result_b got=%0b want=%0b cyc=%0d", out_bit_b, e_b, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b", name, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [2:0] op, input logic e);
    @(negedge clk);
    in_data = d; in_op = op; in_valid = 1'b1;
    #1;
    for (int n = 0; n < 100 && !in_ready; n++) begin
      @(negedge clk);
      #1;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_timeout got=0 want=1");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic send_b(input logic [9:0] d, input logic [2:0] op, input logic e);
    @(negedge clk);
    in_data_b = d; in_op_b = op; in_valid_b = 1'b1;
    #1;
    for (int n = 0; n < 100 && !in_ready_b; n++) begin
      @(negedge clk);
      #1;
    end
    if (!in_ready_b) begin
      total++; bad++;
      $display("FAIL in_ready_b_timeout got=0 want=1");
      in_valid_b = 1'b0;
    end else begin
      exp_qb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (exp_q.size() != 0 || exp_qb.size() != 0); n++) @(negedge clk);
    if (exp_q.size() != 0 || exp_qb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d want=0", exp_q.size() + exp_qb.size());
    end
  endtask

  function automatic logic ref_red(input logic [63:0] d, input logic [2:0] op);
    logic r;
    case (op[1:0])
      2'b01:   r = |d;
      2'b10:   r = ^d;
      default: r = &d;
    endcase
    return r ^ op[2];
  endfunction

  logic [63:0] rd;
  logic [2:0]  rop;
  int          s0;

  initial begin
    reset_n = 1'b0; in_valid = 1'b1; in_data = '0; in_op = '0; out_ready = 1'b1;
    in_valid_b = 1'b1; in_data_b = '0; in_op_b = '0; out_ready_b = 1'b1;

    // reset hold with in_valid asserted
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bit", out_bit, 1'b0);
    check("rst_in_ready_b", in_ready_b, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; in_valid_b = 1'b0; reset_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1'b1);

    // padding on the 10-bit instance
    send_b(10'h3FF, 3'b000, 1'b1);
    send_b(10'h200, 3'b001, 1'b1);
    send_b(10'h201, 3'b010, 1'b0);
    send_b(10'h1FF, 3'b000, 1'b0);
    send_b(10'h3FF, 3'b100, 1'b0);
    send_b(10'h200, 3'b010, 1'b1);
    send_b(10'h000, 3'b101, 1'b1);
    idle();
    drain();

    // NOR zero flag and latency
    send(64'h0, 3'b101, 1'b1);
    idle();
    #1 check("lat_edge1", out_valid, 1'b0);
    @(negedge clk);
    #1 check("lat_edge2", out_valid, 1'b0);
    @(negedge clk);
    #1 check("lat_edge3", out_valid, 1'b1);
    check("nor_zero", out_bit, 1'b1);
    send(64'h1 << 63, 3'b101, 1'b0);
    idle();
    drain();

    // back-to-back stream
    s0 = pop_cyc.size();
    send(64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFE, 3'b000, 1'b0);
    send(64'h7,                   3'b010, 1'b1);
    send(64'h3,                   3'b110, 1'b1);
    send(64'h0,                   3'b001, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b0);
    send(64'h8000_0000_0000_0000, 3'b111, 1'b1);
    idle();
    drain();
    total++;
    if (pop_cyc.size() < s0 + 8) begin
      bad++;
      $display("FAIL stream_count got=%0d want=8", pop_cyc.size() - s0);
    end else if (pop_cyc[s0+7] - pop_cyc[s0] != 7) begin
      bad++;
      $display("FAIL stream_gaps got=%0d want=7", pop_cyc[s0+7] - pop_cyc[s0]);
    end

    // backpressure
    @(negedge clk);
    out_ready = 1'b0;
    send(64'h10, 3'b001, 1'b1);
    send(64'hF0, 3'b010, 1'b0);
    send(64'h10, 3'b101, 1'b0);
    idle();
    #1;
    check("bp_full_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_bit", out_bit, 1'b1);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b1);
    idle();
    drain();

    // reset with two operands in flight
    send(64'h1, 3'b001, 1'b1);
    send(64'h3, 3'b010, 1'b0);
    idle();
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_rel_in_ready", in_ready, 1'b1);
    repeat (6) @(negedge clk);
    #1;
    check("mid_no_ghost", out_valid, 1'b0);
    send(64'h5, 3'b010, 1'b0);
    send(64'h0, 3'b101, 1'b1);
    idle();
    drain();

    // random operands, random backpressure
    rnd_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rd  = {$urandom, $urandom};
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rd = 64'hFFFF_FFFF_FFFF_FFFF;
      else if ($urandom_range(0, 3) == 0) rd = 64'h1 << $urandom_range(0, 63);
      send(rd, rop, ref_red(rd, rop));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rnd_on = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
